adc_serial_responder: RTL
=========================

Name: adc_serial_responder

Overview:
- Emulates the 12-bit serial ADC on the test fixture, as the responder end of the adclk/cs_n/ad_in link.
- Lets the PCB test rig drive known voltage codes into the unit's ADC reader, e.g. to check the 0x860/0x8B0/0xC0C threshold LEDs without high voltage.
- Samples the master's cs_n and adclk on the system clock and shifts out 4 leading zeros followed by a 12-bit code, MSB first.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on adclk_in and cs_n_in (minimum 2).
- DATA_BITS, 12: code width. Frame length is DATA_BITS+4 sclk cycles.
- RAMP_STEP, 1: code increment per completed frame. Used only with RAMP_MODE_EN.

Ports:
- clk  in  1  system clock, 40 MHz; adclk_in must be no faster than clk/8.
- sys_rst_n  in  1  reset, synchronous, active-low.
- adclk_in  in  1  serial clock from the master. Idles high.
- cs_n_in  in  1  frame select from the master, active-low.
- sdo  out  1  serial data to the master's ad_in.
- sdo_oe  out  1  1 while a frame is being driven.
- code_in  in  DATA_BITS  code to present.
- code_we  in  1  1-cycle strobe; loads code_in into the pending register.
- busy  out  1  1 in SHIFT or DONE.
- frame_done  out  1  1-cycle pulse when a full frame completes.
- frame_abort  out  1  1-cycle pulse when cs_n rises early.
- frame_cnt  out  16  count of completed frames; wraps 0xFFFF->0.

Behaviour:
- Clock and reset: single clk domain. sys_rst_n is synchronous and active-low.
- Reset values:
  - Outputs: sdo=0, sdo_oe=0, busy=0, frame_done=0, frame_abort=0, frame_cnt=0.
  - Internal: pending code=0, synchronizer chains=1 (inactive), bit counter=0, state IDLE.
- Input conditioning: both inputs pass through SYNC_STAGES flops plus one edge-detect flop.
  - cs_fall/cs_rise and sclk_fall are single-cycle strobes.
  - sdo update latency: SYNC_STAGES+1 clk after the pin edge (3 clk by default).
- Pending register:
  - code_we=1 loads code_in and is accepted in any state.
  - A write during SHIFT affects only the next frame.
  - code_we in the same cycle as cs_fall: the new code_in is used (write-through).
- State machine:
  - IDLE:
    - sdo=0, sdo_oe=0.
    - cs_fall: load shift register {4'b0, pending}, sdo=bit15 (0), sdo_oe=1, bit counter=0, go to SHIFT.
    - sclk edges are ignored.
  - SHIFT:
    - Each sclk_fall: shift left, sdo=next bit, bit counter+1.
    - On the 16th sclk_fall: sdo=0, frame_done=1 for one cycle, frame_cnt+1, go to DONE.
    - cs_rise before the 16th fall: frame_abort=1 for one cycle, sdo=0, sdo_oe=0, frame_cnt unchanged, go to IDLE.
  - DONE:
    - sdo=0, sdo_oe=1.
    - Extra sclk_fall strobes are ignored.
    - cs_rise: sdo_oe=0, go to IDLE.
- Bit timing:
  - The master samples on the sclk rising edge, so bit15 is valid from cs_n fall to the first sclk fall.
  - Bit k (k=14..0) is valid between sclk falls 15-k and 16-k.
- Simultaneous cs_rise and 16th sclk_fall in SHIFT: treated as a completed frame (done pulses, count increments), then IDLE. No abort.
- Reset mid-frame: return to IDLE immediately. With cs_n_in still low, no frame starts until a fresh high-to-low transition is seen (synchronizers reset high).
- cs_n_in low at power-up behaves the same way: no frame until cs_n has been seen high.

Optional Feature:
- Macro: RAMP_MODE_EN.
- Defined: on each frame_done the pending code becomes (pending+RAMP_STEP) mod 2^DATA_BITS, wrapping 0xFFF->0x000. code_we in the same cycle wins over the increment. Aborted frames do not increment.
- Undefined: the pending code changes only via code_we.

Test Plan:
1. Reset, code_we with code_in=0x8B1, one 16-clock frame at clk/16 -> master shifts in 0x08B1; one frame_done pulse; frame_cnt=1; sdo_oe=1 from cs fall +3 clk until cs rise +3 clk.
2. code_in=0xC0D, then code_we=0x123 mid-frame -> frame 1 reads 0x0C0D, frame 2 reads 0x0123.
3. cs_n rises after 7 sclk -> frame_abort pulses once; frame_cnt unchanged; sdo=0, sdo_oe=0; the next full frame reads correctly.
4. 20 sclk pulses in one frame -> bits 16..19 read 0; exactly one frame_done.
5. Assert sys_rst_n=0 after sclk 5 with cs_n held low, release with cs_n still low -> no shifting and no done until cs_n goes high then low; frame_cnt=0.
6. RAMP_MODE_EN defined, code=0xFFE, 3 frames -> reads 0x0FFE, 0x0FFF, 0x0000; frame_cnt=3.

Source files
------------

// File: rtl/adc_serial_responder_if.sv
// ----------------------------------------------------------------------------
// adc_serial_responder_if
//
// Purpose:
//   Serial link between an ADC reader (master) and the emulated 12-bit serial
//   ADC (responder). The master drives the serial clock and the frame select.
//   The responder returns serial data and an output-enable flag.
//
// Signals:
//   adclk_in  serial clock from the master, idles high
//   cs_n_in   frame select from the master, active-low
//   sdo       serial data to the master's ad_in
//   sdo_oe    high while the responder is driving a frame
//
// Modports:
//   master  drives adclk_in/cs_n_in, receives sdo/sdo_oe
//   slave   receives adclk_in/cs_n_in, drives sdo/sdo_oe
// ----------------------------------------------------------------------------
interface adc_serial_responder_if;
    logic adclk_in;
    logic cs_n_in;
    logic sdo;
    logic sdo_oe;

    modport master (
        output adclk_in,
        output cs_n_in,
        input  sdo,
        input  sdo_oe
    );

    modport slave (
        input  adclk_in,
        input  cs_n_in,
        output sdo,
        output sdo_oe
    );
endinterface

// File: rtl/adc_serial_responder.sv
// ----------------------------------------------------------------------------
// adc_serial_responder
//
// Purpose:
//   Emulates a 12-bit serial ADC as the responder on an adclk/cs_n/ad_in link,
//   so a test rig can feed known codes into the unit's ADC reader. Each frame
//   shifts out 4 leading zeros followed by a DATA_BITS code, MSB first. A new
//   bit is presented after every falling edge of adclk. The master samples
//   the bit on the following rising edge.
//
// Build option:
//   RAMP_MODE_EN  when defined, the pending code advances by RAMP_STEP
//                 (modulo 2^DATA_BITS) after every completed frame.
//                 When undefined, the pending code changes only via code_we.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on adclk_in and cs_n_in (minimum 2)
//   DATA_BITS    code width. A frame is DATA_BITS+4 sclk cycles.
//   RAMP_STEP    code increment per completed frame (ramp build only)
//
// Ports:
//   clk          system clock. adclk must be no faster than clk/8.
//   sys_rst_n    synchronous active-low reset
//   bus          serial link (slave modport): adclk_in, cs_n_in in. sdo, sdo_oe out.
//   code_in      code to present
//   code_we      1-cycle strobe that loads code_in into the pending register
//   busy         high in SHIFT or DONE
//   frame_done   1-cycle pulse when a full frame completes
//   frame_abort  1-cycle pulse when cs_n rises before the frame is complete
//   frame_cnt    count of completed frames. Wraps from 0xFFFF to 0.
// ----------------------------------------------------------------------------
module adc_serial_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 12,
    parameter int RAMP_STEP   = 1
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    adc_serial_responder_if.slave bus,
    input  logic [DATA_BITS-1:0] code_in,
    input  logic                 code_we,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic [15:0]          frame_cnt
);

    localparam int FRAME_BITS = DATA_BITS + 4;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [DATA_BITS-1:0] RAMP_INC = DATA_BITS'(RAMP_STEP);

`ifdef RAMP_MODE_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;
    // fill_q marks when the synchronizers and edge flops hold real pin
    // history instead of reset values. Until then, no edge is reported, so
    // a cs_n that is already low when reset is released cannot start a
    // frame. The pin must be seen high and then low first.
    logic [SYNC_STAGES:0]   fill_q;

    logic sclk_s;
    logic cs_s;
    logic hist_valid;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
            fill_q      <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.adclk_in};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n_in};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
            fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign hist_valid = fill_q[SYNC_STAGES];

    assign sclk_fall = hist_valid &  sclk_prev_q & ~sclk_s;
    assign cs_fall   = hist_valid &  cs_prev_q   & ~cs_s;
    assign cs_rise   = hist_valid & ~cs_prev_q   &  cs_s;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t                  state_q,       state_d;
    // Holds the bits still to be sent. The bit on the pin is held in sdo_q.
    logic [FRAME_BITS-2:0]   shift_q,       shift_d;
    logic [CNT_W-1:0]        bit_cnt_q,     bit_cnt_d;
    logic                    sdo_q,         sdo_d;
    logic                    sdo_oe_q,      sdo_oe_d;
    logic                    frame_done_q,  frame_done_d;
    logic                    frame_abort_q, frame_abort_d;
    logic [15:0]             frame_cnt_q,   frame_cnt_d;
    logic [DATA_BITS-1:0]    pending_q,     pending_d;

    logic [DATA_BITS-1:0]    load_code;
    logic [FRAME_BITS-1:0]   load_word;
    logic                    last_bit;

    // A write in the same cycle as the frame start is used by that frame.
    assign load_code = code_we ? code_in : pending_q;
    assign load_word = {4'b0000, load_code};
    assign last_bit  = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            sdo_q         <= 1'b0;
            sdo_oe_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            frame_cnt_q   <= '0;
            pending_q     <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            sdo_q         <= sdo_d;
            sdo_oe_q      <= sdo_oe_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
            frame_cnt_q   <= frame_cnt_d;
            pending_q     <= pending_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        sdo_d         = sdo_q;
        sdo_oe_d      = sdo_oe_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                sdo_d    = 1'b0;
                sdo_oe_d = 1'b0;
                if (cs_fall) begin
                    // The MSB goes on the pin at once. The rest waits in the
                    // shift register for the sclk falls.
                    sdo_d     = load_word[FRAME_BITS-1];
                    shift_d   = load_word[FRAME_BITS-2:0];
                    sdo_oe_d  = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (sclk_fall && last_bit) begin
                    // Final fall wins over a simultaneous cs rise. The frame
                    // counts as complete either way.
                    sdo_d        = 1'b0;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    bit_cnt_d    = bit_cnt_q + CNT_W'(1);
                    if (cs_rise) begin
                        sdo_oe_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end else if (cs_rise) begin
                    frame_abort_d = 1'b1;
                    sdo_d         = 1'b0;
                    sdo_oe_d      = 1'b0;
                    state_d       = ST_IDLE;
                end else if (sclk_fall) begin
                    sdo_d     = shift_q[FRAME_BITS-2];
                    shift_d   = {shift_q[FRAME_BITS-3:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                // Surplus sclk falls are ignored. The line stays driven low
                // until the master releases cs.
                sdo_d    = 1'b0;
                sdo_oe_d = 1'b1;
                if (cs_rise) begin
                    sdo_oe_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                sdo_d    = 1'b0;
                sdo_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Pending code: a host write takes priority over the ramp increment.
    always_comb begin
        pending_d = pending_q;
        if (RAMP_ON && frame_done_d) begin
            pending_d = pending_q + RAMP_INC;
        end
        if (code_we) begin
            pending_d = code_in;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.sdo     = sdo_q;
    assign bus.sdo_oe  = sdo_oe_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
